// File: rtl/updown_counter_n.sv
// updown_counter_n: generic up/down counter with programmable terminal, load, saturation and cascade carry
module updown_counter_n #(
    parameter int unsigned WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic             U_DB,
    input  logic             ENPB,
    input  logic             ENTB,
    input  logic             LOADB,
    output logic [WIDTH-1:0] Q,
    output logic             RCOB,
    output logic             WRAP
);
    logic at_top, at_zero, over, count_en, wrap_next;
    logic [WIDTH-1:0] count_next;
    assign at_top   = Q >= MAX_VAL;
    assign at_zero  = Q == '0;
    assign over     = Q > MAX_VAL;
    assign count_en = LOADB && !ENPB && !ENTB;
    assign RCOB     = !(!ENTB && (U_DB ? at_top : at_zero));
    // Terminals are found by comparison, so out-of-range loads re-enter the range instead of overflowing
    always_comb begin
        count_next = U_DB ? (at_top ? (SATURATE ? MAX_VAL : '0) : Q + 1'b1)
                          : (over ? MAX_VAL : at_zero ? (SATURATE ? '0 : MAX_VAL) : Q - 1'b1);
        wrap_next  = !SATURATE && (U_DB ? at_top : (at_zero && !over));
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q    <= '0;
            WRAP <= 1'b0;
        end else if (!LOADB) begin
            Q    <= A;
            WRAP <= 1'b0;
        end else begin
            Q    <= count_en ? count_next : Q;
            WRAP <= count_en && wrap_next;
        end
    end
endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: wrap/saturate decade counters plus a two-digit BCD cascade checked against a behavioural model
module tb_updown_counter_n;
    localparam int MAXV = 9;
    logic       CLK = 1'b0;
    logic       RST, U_DB, ENPB, ENTB, LOADB, c_entb;
    logic [3:0] A;
    logic [3:0] q0, q1, lo_q, hi_q;
    logic       rc0, rc1, lo_rc, hi_rc, w0, w1, lo_w, hi_w;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap (
        .CLK(CLK), .RST(RST), .A(A), .U_DB(U_DB), .ENPB(ENPB), .ENTB(ENTB), .LOADB(LOADB),
        .Q(q0), .RCOB(rc0), .WRAP(w0));
    updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat (
        .CLK(CLK), .RST(RST), .A(A), .U_DB(U_DB), .ENPB(ENPB), .ENTB(ENTB), .LOADB(LOADB),
        .Q(q1), .RCOB(rc1), .WRAP(w1));
    updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_lo (
        .CLK(CLK), .RST(RST), .A(4'd0), .U_DB(U_DB), .ENPB(ENPB), .ENTB(c_entb), .LOADB(1'b1),
        .Q(lo_q), .RCOB(lo_rc), .WRAP(lo_w));
    updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_hi (
        .CLK(CLK), .RST(RST), .A(4'd0), .U_DB(U_DB), .ENPB(ENPB), .ENTB(lo_rc), .LOADB(1'b1),
        .Q(hi_q), .RCOB(hi_rc), .WRAP(hi_w));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nxt(input int q, input bit up, input bit sat, output bit w);
        w = 1'b0;
        if (up) begin
            if (q < MAXV) return q + 1;
            w = !sat;
            return sat ? MAXV : 0;
        end
        if (q > MAXV) return MAXV;
        if (q > 0) return q - 1;
        w = !sat;
        return sat ? 0 : MAXV;
    endfunction

    function automatic bit rcob_of(input int q, input bit entb, input bit up);
        return !(!entb && (up ? q >= MAXV : q == 0));
    endfunction

    // Reference model: single digits by the counting rules, the cascade as one integer modulo 100
    int m0, m1, cnt;
    bit mw0, mw1, cw, valid = 1'b0;
    always @(posedge CLK) begin
        if (RST) begin
            m0 = 0; m1 = 0; mw0 = 0; mw1 = 0; cnt = 0; cw = 0; valid = 1'b1;
        end else begin
            if (!LOADB) begin
                m0 = int'(A); m1 = int'(A); mw0 = 0; mw1 = 0;
            end else if (!ENPB && !ENTB) begin
                m0 = nxt(m0, U_DB, 1'b0, mw0);
                m1 = nxt(m1, U_DB, 1'b1, mw1);
            end else begin
                mw0 = 0; mw1 = 0;
            end
            if (!ENPB && !c_entb) begin
                cw  = U_DB ? cnt == 99 : cnt == 0;
                cnt = U_DB ? (cnt + 1) % 100 : (cnt + 99) % 100;
            end else cw = 0;
        end
        #1;
        if (valid) begin
            chk("wrap_q", q0, m0);
            chk("wrap_wrap", w0, mw0);
            chk("wrap_rcob", rc0, rcob_of(m0, ENTB, U_DB));
            chk("sat_q", q1, m1);
            chk("sat_wrap", w1, mw1);
            chk("sat_rcob", rc1, rcob_of(m1, ENTB, U_DB));
            chk("bcd_value", hi_q * 10 + lo_q, cnt);
            chk("bcd_hi_wrap", hi_w, cw);
            chk("bcd_top_rcob", hi_rc, !(!c_entb && (U_DB ? cnt == 99 : cnt == 0)));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load(input logic [3:0] v);
        LOADB = 1'b0; A = v;
        step(1);
        LOADB = 1'b1;
    endtask

    initial begin
        RST = 1'b1; LOADB = 1'b1; ENPB = 1'b1; ENTB = 1'b1; U_DB = 1'bx; A = 4'bx; c_entb = 1'b1;
        step(1);
        chk("reset_q", q0, 0);
        chk("reset_wrap", w0, 0);
        // up count through the decade terminal
        RST = 1'b0; U_DB = 1'b1; A = 4'd0; ENPB = 1'b0; ENTB = 1'b0;
        step(9);
        chk("up_q9", q0, 9);
        chk("up_rcob9", rc0, 0);
        step(1);
        chk("up_wrap_q", q0, 0);
        chk("up_wrap_pulse", w0, 1);
        chk("sat_hold9", q1, 9);
        step(2);
        chk("up_q2", q0, 2);
        chk("up_wrap_clear", w0, 0);
        // down count through zero
        load(4'd2);
        U_DB = 1'b0;
        step(2);
        chk("dn_q0", q0, 0);
        chk("dn_rcob0", rc0, 0);
        step(1);
        chk("dn_wrap_q", q0, 9);
        chk("dn_wrap_pulse", w0, 1);
        step(1);
        chk("dn_q8", q0, 8);
        // saturation
        load(4'd7);
        U_DB = 1'b1;
        step(5);
        chk("sat_up_q", q1, 9);
        chk("sat_up_wrap", w1, 0);
        load(4'd1);
        U_DB = 1'b0;
        step(2);
        chk("sat_dn_q", q1, 0);
        chk("sat_dn_wrap", w1, 0);
        // priority
        load(4'd5);
        LOADB = 1'b0; A = 4'd3;
        step(1);
        chk("load_over_count", q0, 3);
        RST = 1'b1; A = 4'd7;
        step(1);
        chk("reset_over_load", q0, 0);
        RST = 1'b0;
        load(4'd9);
        ENPB = 1'b1; U_DB = 1'b1;
        step(2);
        chk("enpb_hold", q0, 9);
        chk("enpb_rcob", rc0, 0);
        U_DB = 1'b0; #1;
        chk("rcob_dir_change", rc0, 1);
        U_DB = 1'b1; ENTB = 1'b1; #1;
        chk("rcob_entb_gate", rc0, 1);
        step(1);
        // out-of-range load
        ENPB = 1'b0; ENTB = 1'b0;
        load(4'd13);
        step(1);
        chk("oor_up_q", q0, 0);
        chk("oor_up_wrap", w0, 1);
        chk("oor_up_sat_q", q1, 9);
        load(4'd13);
        U_DB = 1'b0;
        step(1);
        chk("oor_dn_q", q0, 9);
        chk("oor_dn_wrap", w0, 0);
        // BCD cascade
        ENTB = 1'b1; U_DB = 1'b1; c_entb = 1'b0;
        step(99);
        chk("bcd_99_hi", hi_q, 9);
        chk("bcd_99_lo", lo_q, 9);
        chk("bcd_99_rcob", hi_rc, 0);
        step(1);
        chk("bcd_00", {hi_q, lo_q}, 0);
        chk("bcd_00_wrap", hi_w, 1);
        U_DB = 1'b0;
        step(1);
        chk("bcd_dn_99", {hi_q, lo_q}, 8'h99);
        c_entb = 1'b1;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
- Parametrised synchronous up/down binary counter with a programmable terminal value, a parallel load, and active-low dual count enables.
- Next-generation, generalised 74x169-style counter for the team's TTL-equivalent library.
- Adds generic width, a non-power-of-two modulus (e.g. decade), optional saturation, a synchronous reset, a cascadable combinational ripple-carry, and a registered wrap pulse.
- Instances cascade into wider counters by chaining RCOB into the next stage's ENTB.

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- MAX_VAL, 2**WIDTH-1, upper terminal value; up-count wraps after it, down-count wraps to it. Must be >0 and <2**WIDTH.
- SATURATE, 0, 0 = wrap at terminals; 1 = hold at terminals.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- A  input  WIDTH  parallel load data.
- U_DB  input  1  direction: 1 = up, 0 = down.
- ENPB  input  1  count enable P, active low.
- ENTB  input  1  count enable T, active low; also gates RCOB.
- LOADB  input  1  synchronous load, active low.
- Q  output  WIDTH  counter value (registered).
- RCOB  output  1  ripple-carry out, active low, combinational.
- WRAP  output  1  registered one-cycle pulse following a wrap.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). Priority on each rising CLK edge: RST > LOADB > count > hold.
- RST=1: Q<=0, WRAP<=0. Other inputs are ignored that cycle. Reset asserted mid-count wins over load and count.
- LOADB=0 (RST=0): Q<=A regardless of ENPB/ENTB/U_DB. WRAP<=0.
  - A>MAX_VAL is loaded unchanged (no clamping).
- Count enable: LOADB=1 and ENPB=0 and ENTB=0. Otherwise Q holds and WRAP<=0.
- Up count (U_DB=1):
  - Q<MAX_VAL: Q<=Q+1.
  - Q>=MAX_VAL, SATURATE=0: Q<=0, WRAP<=1.
  - Q>=MAX_VAL, SATURATE=1: Q<=MAX_VAL, WRAP<=0.
- Down count (U_DB=0):
  - Q>0 and Q<=MAX_VAL: Q<=Q-1.
  - Q>MAX_VAL (out-of-range load): Q<=MAX_VAL, WRAP<=0 in either mode.
  - Q==0, SATURATE=0: Q<=MAX_VAL, WRAP<=1.
  - Q==0, SATURATE=1: Q<=0, WRAP<=0.
- WRAP is high for exactly the cycle after a wrapping edge. It is never asserted by load, reset or saturation.
- RCOB is combinational and active low: RCOB=0 iff ENTB=0 and ((U_DB=1 and Q>=MAX_VAL) or (U_DB=0 and Q==0)). Otherwise RCOB=1.
  - RCOB is independent of ENPB and LOADB, as needed for look-ahead cascading.
  - RCOB updates immediately on U_DB or ENTB changes.
- Cascade rule: stage n's RCOB drives stage n+1's ENTB, and all stages share ENPB. The upper stage advances exactly on the edge where the lower stage wraps.
- A direction change takes effect on the next edge. There is no pipeline; count latency is 1 cycle.
- Arithmetic is unsigned WIDTH-bit. No intermediate result exceeds WIDTH bits, because wrap is decided by comparison, not overflow.
- There is no X-propagation into Q after reset, even if A/U_DB were X before reset.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0: RST 1 cycle, then ENPB=ENTB=0, LOADB=1, U_DB=1 for 12 edges -> Q=1..9,0,1,2. WRAP high only in the cycle Q first reads 0. RCOB=0 only while Q=9.
- Same config, down: load A=2, count 4 edges -> Q=2,1,0,9,8. WRAP=1 the cycle Q=9. RCOB=0 while Q=0 and U_DB=0.
- SATURATE=1, MAX_VAL=9: count up from 7 for 5 edges -> 8,9,9,9,9 with WRAP=0. Count down from 1 -> 0,0 with WRAP=0.
- Priority: at Q=5 assert LOADB=0, A=3, ENPB=ENTB=0 -> Q=3. Assert RST=1 and LOADB=0 together -> Q=0. ENPB=1 with ENTB=0 -> Q holds, while RCOB still tracks terminal.
- Out-of-range load, MAX_VAL=9: load A=13. U_DB=1 one edge -> Q=0 with WRAP=1. Reload 13, U_DB=0 one edge -> Q=9 with WRAP=0.
- Cascade two WIDTH=4, MAX_VAL=9 instances into a BCD 00..99 counter: 100 enables -> reads 99 then 00. The high digit increments only on low-digit 9->0 edges. The top RCOB=0 only at 99 with ENTB low.
